// File: rtl/hist_eq_pkg.sv
// Shared histogram-equalization definitions: datapath widths, the CDF pass FSM
// state type and the saturating accumulate used by the running sum.
package hist_eq_pkg;

  localparam int HEQ_DATA_W   = 20;
  localparam int HEQ_ADDR_W   = 16;
  localparam int HEQ_NUM_BINS = 256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } cdf_state_e;

  typedef struct packed {
    logic                  sat;
    logic [HEQ_DATA_W-1:0] sum;
  } sat_sum_t;

  // Add one bin at DATA_W+1 bits; a carry out clamps the sum to all-ones.
  function automatic sat_sum_t sat_add(input logic [HEQ_DATA_W-1:0] a,
                                       input logic [HEQ_DATA_W-1:0] b);
    logic [HEQ_DATA_W:0] wide;
    sat_sum_t            res;
    wide    = {1'b0, a} + {1'b0, b};
    res.sat = wide[HEQ_DATA_W];
    res.sum = wide[HEQ_DATA_W] ? '1 : wide[HEQ_DATA_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/cdf_accumulate_if.sv
// Scratchpad port bundle of the CDF pass: histogram read side and CDF write side.
interface cdf_accumulate_if
  import hist_eq_pkg::*;
#(
  parameter int DATA_W = HEQ_DATA_W,
  parameter int ADDR_W = HEQ_ADDR_W
);
  logic [ADDR_W-1:0] Hist_ReadAddress;
  logic [DATA_W-1:0] Hist_ReadBus;
  logic              Cdf_WriteEnable;
  logic [ADDR_W-1:0] Cdf_WriteAddress;
  logic [DATA_W-1:0] Cdf_WriteBus;

  modport master (
    output Hist_ReadAddress,
    input  Hist_ReadBus,
    output Cdf_WriteEnable,
    output Cdf_WriteAddress,
    output Cdf_WriteBus
  );

  modport slave (
    input  Hist_ReadAddress,
    output Hist_ReadBus,
    input  Cdf_WriteEnable,
    input  Cdf_WriteAddress,
    input  Cdf_WriteBus
  );
endinterface

// File: rtl/cdf_accumulate.sv
// Streams every histogram bin through a saturating running sum, writes the CDF
// scratchpad and produces the CdfMin/divisor operands for the output pipeline.
module cdf_accumulate
  import hist_eq_pkg::*;
#(
  parameter int                NUM_BINS  = HEQ_NUM_BINS,
  parameter int                DATA_W    = HEQ_DATA_W,
  parameter int                ADDR_W    = HEQ_ADDR_W,
  parameter logic [ADDR_W-1:0] HIST_BASE = '0,
  parameter logic [ADDR_W-1:0] CDF_BASE  = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  cdf_accumulate_if.master  mem,
  output logic [DATA_W-1:0] CdfMin,
  output logic [DATA_W-1:0] divisor,
  output logic              overflow,
  output logic              done
);

  localparam int IDX_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

  cdf_state_e        state_q;
  logic [IDX_W-1:0]  idx_q, idx1_q, idx2_q;
  logic              v1_q, v2_q, drain_q;
  logic [DATA_W-1:0] sum_q, min_q;
  logic              min_found_q, run_ovf_q;
  logic [ADDR_W-1:0] addr_q, wr_addr_q;
  logic              wr_en_q;
  logic [DATA_W-1:0] wr_data_q, cdf_min_q, divisor_q;
  logic              overflow_q, done_q;

  sat_sum_t          acc_d;
  logic [DATA_W-1:0] div_raw, divisor_d;

  // NOTE: every variable gets a value before any condition, so no latch is inferred.
  always_comb begin
    acc_d     = sat_add(sum_q, mem.Hist_ReadBus);
    div_raw   = sum_q - min_q;
    divisor_d = (div_raw == '0) ? DATA_W'(1) : div_raw;
  end

  // NOTE: all state updates are non-blocking so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      idx1_q      <= '0;
      idx2_q      <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      drain_q     <= 1'b0;
      sum_q       <= '0;
      min_q       <= '0;
      min_found_q <= 1'b0;
      run_ovf_q   <= 1'b0;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cdf_min_q   <= '0;
      divisor_q   <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= v1_q;
      idx2_q  <= idx1_q;
      wr_en_q <= v2_q;

      // Bin data arrives two cycles after its address; fold it in and write it out.
      if (v2_q) begin
        sum_q     <= acc_d.sum;
        wr_addr_q <= CDF_BASE + ADDR_W'(idx2_q);
        wr_data_q <= acc_d.sum;
        if (acc_d.sat) run_ovf_q <= 1'b1;
        if (!min_found_q && (acc_d.sum != '0)) begin
          min_found_q <= 1'b1;
          min_q       <= acc_d.sum;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_READ;
            idx_q       <= '0;
            sum_q       <= '0;
            min_q       <= '0;
            min_found_q <= 1'b0;
            run_ovf_q   <= 1'b0;
          end
        end
        ST_READ: begin
          addr_q <= HIST_BASE + ADDR_W'(idx_q);
          v1_q   <= 1'b1;
          idx1_q <= idx_q;
          idx_q  <= idx_q + 1'b1;
          if (idx_q == IDX_W'(NUM_BINS - 1)) begin
            state_q <= ST_DRAIN;
            drain_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          addr_q  <= '0;
          drain_q <= 1'b1;
          if (drain_q) state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q     <= 1'b1;
          cdf_min_q  <= min_q;
          divisor_q  <= divisor_d;
          overflow_q <= run_ovf_q;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem.Hist_ReadAddress = addr_q;
  assign mem.Cdf_WriteEnable  = wr_en_q;
  assign mem.Cdf_WriteAddress = wr_addr_q;
  assign mem.Cdf_WriteBus     = wr_data_q;
  assign CdfMin               = cdf_min_q;
  assign divisor              = divisor_q;
  assign overflow             = overflow_q;
  assign done                 = done_q;

endmodule

// File: tb/tb_cdf_accumulate.sv
// Directed bench for cdf_accumulate: histogram memory model, CDF write capture
// and hand-computed expected CDFs/operands for each scenario.
module tb_cdf_accumulate;
  import hist_eq_pkg::*;

  localparam int            NB = 256;
  localparam int            DW = 20;
  localparam int            AW = 16;
  localparam logic [AW-1:0] HB = 16'h1000;
  localparam logic [AW-1:0] CB = 16'h0200;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] CdfMin, divisor;
  logic          overflow, done;

  cdf_accumulate_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  cdf_accumulate #(
    .NUM_BINS (NB),
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .HIST_BASE(HB),
    .CDF_BASE (CB)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .mem     (bus.master),
    .CdfMin  (CdfMin),
    .divisor (divisor),
    .overflow(overflow),
    .done    (done)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Histogram memory with a one-cycle registered read.
  logic [DW-1:0] hist_mem[NB];
  logic [AW-1:0] rd_off;
  always @(posedge clock) begin
    rd_off = bus.Hist_ReadAddress - HB;
    bus.Hist_ReadBus <= hist_mem[rd_off[7:0]];
  end

  logic [DW-1:0] cdf_mem[NB];
  logic [DW-1:0] exp_cdf[NB];
  int            edge_cnt = 0;
  int            t0 = 0;
  int            mon_cyc;
  int            wr_cnt, first_wr, last_wr, addr_bad, done_cnt, done_cyc;
  logic [DW-1:0] cap_min, cap_div;
  logic          cap_ovf;
  logic [AW-1:0] addr_c1, addr_c256, wr_off;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  // Capture writes and the done pulse, timestamped relative to the start edge.
  always @(negedge clock) begin
    mon_cyc = edge_cnt - t0;
    if (bus.Cdf_WriteEnable) begin
      if (bus.Cdf_WriteAddress != CB + AW'(wr_cnt)) addr_bad++;
      wr_off = bus.Cdf_WriteAddress - CB;
      if (wr_off < NB) cdf_mem[wr_off[7:0]] = bus.Cdf_WriteBus;
      if (wr_cnt == 0) first_wr = mon_cyc;
      last_wr = mon_cyc;
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = mon_cyc;
      cap_min  = CdfMin;
      cap_div  = divisor;
      cap_ovf  = overflow;
    end
    if (mon_cyc == 1)   addr_c1   = bus.Hist_ReadAddress;
    if (mon_cyc == 256) addr_c256 = bus.Hist_ReadAddress;
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic launch(input bit hold);
    wr_cnt    = 0;
    first_wr  = -1;
    last_wr   = -1;
    addr_bad  = 0;
    done_cnt  = 0;
    done_cyc  = -1;
    addr_c1   = '1;
    addr_c256 = '1;
    for (int i = 0; i < NB; i++) cdf_mem[i] = 20'hABCDE;
    t0    = edge_cnt + 1;
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 400; k++) begin
      if (done_cnt != 0) break;
      step();
    end
  endtask

  task automatic check_pass(input string name, input logic [DW-1:0] exp_min,
                            input logic [DW-1:0] exp_div, input logic exp_ovf);
    int bad;
    bad = 0;
    for (int i = 0; i < NB; i++) if (cdf_mem[i] !== exp_cdf[i]) bad++;
    check({name, "_cdf_bad_bins"}, bad, 0);
    check({name, "_write_count"}, wr_cnt, NB);
    check({name, "_first_write_cyc"}, first_wr, 3);
    check({name, "_last_write_cyc"}, last_wr, 258);
    check({name, "_write_addr_bad"}, addr_bad, 0);
    check({name, "_done_count"}, done_cnt, 1);
    check({name, "_done_cyc"}, done_cyc, 259);
    check({name, "_rd_addr_c1"}, addr_c1, HB);
    check({name, "_rd_addr_c256"}, addr_c256, HB + 16'd255);
    check({name, "_cdf_min"}, cap_min, exp_min);
    check({name, "_divisor"}, cap_div, exp_div);
    check({name, "_overflow"}, cap_ovf, exp_ovf);
  endtask

  task automatic set_uniform();
    for (int i = 0; i < NB; i++) begin
      hist_mem[i] = 20'd4;
      exp_cdf[i]  = DW'(4 * (i + 1));
    end
  endtask

  task automatic set_single();
    for (int i = 0; i < NB; i++) begin
      hist_mem[i] = (i == 100) ? 20'd4096 : 20'd0;
      exp_cdf[i]  = (i < 100) ? 20'd0 : 20'd4096;
    end
  endtask

  task automatic set_zero();
    for (int i = 0; i < NB; i++) begin
      hist_mem[i] = 20'd0;
      exp_cdf[i]  = 20'd0;
    end
  endtask

  task automatic set_sat();
    for (int i = 0; i < NB; i++) begin
      hist_mem[i] = (i < 2) ? 20'hFFFFF : 20'd0;
      exp_cdf[i]  = 20'hFFFFF;
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_rd_addr"}, bus.Hist_ReadAddress, 0);
    check({name, "_wr_en"}, bus.Cdf_WriteEnable, 0);
    check({name, "_cdf_min"}, CdfMin, 0);
    check({name, "_divisor"}, divisor, 0);
    check({name, "_overflow"}, overflow, 0);
    check({name, "_done"}, done, 0);
  endtask

  int wr_snap;
  int hold_bad;

  initial begin
    set_zero();
    repeat (3) step();
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) step();

    set_uniform();
    launch(1'b0);
    wait_done();
    repeat (10) step();
    check_pass("uniform", 20'd4, 20'd1020, 1'b0);
    check("uniform_hold_min", CdfMin, 20'd4);
    check("uniform_hold_div", divisor, 20'd1020);

    set_single();
    launch(1'b0);
    wait_done();
    repeat (10) step();
    check_pass("single", 20'd4096, 20'd1, 1'b0);

    set_zero();
    launch(1'b0);
    wait_done();
    repeat (10) step();
    check_pass("zero", 20'd0, 20'd1, 1'b0);

    set_sat();
    launch(1'b0);
    wait_done();
    repeat (10) step();
    check_pass("sat", 20'hFFFFF, 20'd1, 1'b1);
    check("sat_sticky_overflow", overflow, 1'b1);

    // Reset asserted during cycle 100 of a pass.
    set_uniform();
    launch(1'b0);
    for (int k = 0; k < 200 && (edge_cnt - t0) < 100; k++) step();
    reset_n = 1'b0;
    step();
    check_all_zero("midreset");
    reset_n = 1'b1;
    wr_snap = wr_cnt;
    repeat (300) step();
    check("midreset_no_writes", wr_cnt, wr_snap);
    check("midreset_no_done", done_cnt, 0);
    launch(1'b0);
    wait_done();
    repeat (10) step();
    check_pass("after_reset", 20'd4, 20'd1020, 1'b0);

    // start held high for the whole pass, dropped in the done cycle.
    set_single();
    launch(1'b1);
    wait_done();
    start = 1'b0;
    repeat (10) step();
    check_pass("held_start", 20'd4096, 20'd1, 1'b0);

    // Back-to-back passes: operands of the first must hold until the second's done.
    set_single();
    launch(1'b0);
    wait_done();
    check_pass("b2b_first", 20'd4096, 20'd1, 1'b0);
    set_uniform();
    launch(1'b0);
    hold_bad = 0;
    for (int k = 0; k < 400; k++) begin
      if (done_cnt != 0) break;
      if (CdfMin !== 20'd4096 || divisor !== 20'd1) hold_bad++;
      step();
    end
    check("b2b_operand_hold", hold_bad, 0);
    repeat (10) step();
    check_pass("b2b_second", 20'd4, 20'd1020, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdf_accumulate.md
# cdf_accumulate

Upstream neighbour of the output pipeline in the histogram-equalization datapath. After the histogram memory is fully populated, this block streams all bins through a running sum, writes the cumulative distribution (CDF) into the CDF scratchpad that the output pipeline later reads, and computes the `CdfMin` and `divisor` operands that the output stage needs. Its one-cycle `done` pulse is the `start` for the output pipeline.

## Interface
**Parameters**
- `NUM_BINS`, default 256: histogram bins, one per 8-bit intensity.
- `DATA_W`, default 20: count, CDF and operand width.
- `ADDR_W`, default 16: scratchpad address width.
- `HIST_BASE`, default 16'h0000: address of bin 0 in histogram memory.
- `CDF_BASE`, default 16'h0000: address of bin 0 in CDF memory.

**Ports** (`name  direction  width  meaning`)
- `clock  in  1`: single clock, rising edge.
- `reset_n  in  1`: synchronous, active-low reset.
- `start  in  1`: begin a pass; sampled only in IDLE.
- `Hist_ReadAddress  out  ADDR_W`: histogram read address (registered).
- `Hist_ReadBus  in  DATA_W`: histogram data, valid 1 cycle after its address.
- `Cdf_WriteEnable  out  1`: CDF write strobe.
- `Cdf_WriteAddress  out  ADDR_W`: CDF write address.
- `Cdf_WriteBus  out  DATA_W`: CDF write data.
- `CdfMin  out  DATA_W`: first nonzero CDF value.
- `divisor  out  DATA_W`: total minus CdfMin, clamped to at least 1.
- `overflow  out  1`: sticky flag; the running sum saturated during the last pass.
- `done  out  1`: one-cycle pulse at the end of a pass.

## Operation
- **FSM states:** IDLE, READ, DRAIN, DONE.
- **IDLE → READ:** on `start`=1. This clears the accumulator, the read index, the min-found flag and the run-local overflow flag.
- **READ:** issues `HIST_BASE+i` for i=0..NUM_BINS-1, one per cycle. After the last address is issued, the FSM goes to DRAIN.
- **DRAIN:** waits for the last data and the last write to retire (2 cycles), then goes to DONE.
- **DONE:** pulses `done` and latches `CdfMin`, `divisor` and `overflow`, then returns to IDLE.
- **Accumulate:** `sum_i = sat(sum_{i-1} + hist_i)`, computed at DATA_W+1 bits.
  - If the result exceeds 2^DATA_W−1, the sum is clamped to all-ones and the run overflow flag is set.
  - Once saturated, the sum stays at all-ones.
- **Write:** `Cdf_WriteAddress = CDF_BASE+i`, `Cdf_WriteBus = sum_i`. A write occurs for every bin, including zero bins.
- **CdfMin:** `sum_i` of the first bin with `sum_i ≠ 0`. If every bin is zero, CdfMin = 0.
- **divisor:** `total − CdfMin`, where total is the final sum. If the result is 0, divisor = 1. This avoids divide-by-zero downstream.
- **Output hold:** `CdfMin`, `divisor` and `overflow` change only in DONE. They hold their values through the next pass, so the output stage may still be using them.
- **start while not IDLE:** ignored. It is not queued.
- **Reset (including mid-pass):** at the next edge all outputs are 0 and the FSM is in IDLE. No further writes are issued. Partially written CDF contents are undefined.

## Timing
Cycle 0 is the edge at which `start` is sampled in IDLE.

- `Hist_ReadAddress = HIST_BASE+i` is valid in cycle 1+i. `Hist_ReadBus` for bin i is valid in cycle 2+i.
- `Cdf_WriteEnable`=1 with bin i is driven in cycle 3+i. With defaults, writes occur in cycles 3..258.
- `done`=1 in cycle NUM_BINS+3 (259 with defaults). `CdfMin`, `divisor` and `overflow` are valid in that same cycle.
- The earliest accepted next `start` is the cycle after `done`. Throughput is one bin per cycle with no bubbles.
- Reset values of all outputs are 0. `Hist_ReadAddress` is also 0 in IDLE.
- `Cdf_WriteEnable` is 0 in every cycle other than the write window.

## Structure
- **Shared package** (`hist_eq_pkg`) holds:
  - `DATA_W`, `ADDR_W` and `NUM_BINS` constants, common with the output pipeline.
  - The FSM state enum type.
  - A saturating-add function.
- **Single module:** no sub-module is required. The read-index counter, the 2-stage valid/index delay line, the accumulator and the min tracker are all local.
- **Size:** about 150–250 lines of RTL.

## Test plan
- **Uniform histogram:** every bin = 4 → `cdf[i] = 4(i+1)`, CdfMin = 4, divisor = 1020, overflow = 0, `done` in cycle 259.
- **Single occupied bin:** bin 100 = 4096, all other bins 0 → cdf[0..99] = 0 and cdf[100..255] = 4096; CdfMin = 4096; divisor clamped to 1.
- **All-zero histogram:** → 256 writes of 0, CdfMin = 0, divisor = 1, `done` still in cycle 259.
- **Saturation:** bins 0 and 1 = 20'hFFFFF, the rest 0 → cdf[0] = FFFFF, cdf[1..255] = FFFFF, overflow = 1, CdfMin = FFFFF, divisor = 1.
- **Reset mid-pass:** `reset_n`=0 in cycle 100 → all outputs 0 at the next edge and no writes afterward. A fresh `start` then reproduces the uniform-histogram case exactly, with overflow = 0.
- **start handling:**
  - `start` held high throughout a pass → ignored; exactly 256 writes and one `done`.
  - `start` asserted in the cycle after `done` → a second pass runs.
  - `CdfMin` and `divisor` keep the first pass's values until the second pass's `done`.
